// File: rtl/pipe_dbg_ctrl_if.sv
// Register-dump stream between the debug controller and the debug host.
// The controller drives the word, index and done pulse; the host answers with ready.
interface pipe_dbg_ctrl_if;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned IDX_W  = 5;

    logic              dump_valid;
    logic [DATA_W-1:0] dump_data;
    logic [IDX_W-1:0]  dump_idx;
    logic              dump_done;
    logic              dump_ready;

    modport master (output dump_valid, dump_data, dump_idx, dump_done, input dump_ready);
    modport slave  (input dump_valid, dump_data, dump_idx, dump_done, output dump_ready);
endinterface

// File: rtl/pipe_dbg_ctrl.sv
// Run/halt/single-step control and register-file dump for the 5-stage pipeline.
// pipe_en/halted/busy decode directly from state; every other output is registered.
module pipe_dbg_ctrl #(
    parameter bit          RESET_RUN = 1'b1,
    parameter int unsigned RD_LAT    = 1
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  cmd_run,
    input  logic                  cmd_halt,
    input  logic                  cmd_step,
    input  logic                  cmd_dump,
    input  logic [7:0]            step_n,
    input  logic                  wpcir,
    input  logic [31:0]           testdat,
    output logic                  pipe_en,
    output logic                  halted,
    output logic                  busy,
    output logic [4:0]            testreg,
    output logic [31:0]           adv_cnt,
    pipe_dbg_ctrl_if.master       dump
);
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned IDX_W  = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned LAT_W  = 2;
    localparam int unsigned ADV_W  = 32;

    typedef enum logic [2:0] {
        S_RUN  = 3'd0,
        S_HALT = 3'd1,
        S_STEP = 3'd2,
        S_DRD  = 3'd3,
        S_DOUT = 3'd4
    } state_t;

    localparam state_t RST_STATE = RESET_RUN ? S_RUN : S_HALT;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [LAT_W-1:0]    lat_q, lat_d;
    logic                valid_q, valid_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [IDX_W-1:0]    didx_q, didx_d;
    logic                done_q, done_d;
    logic [ADV_W-1:0]    adv_q;

    assign pipe_en = (state_q == S_RUN) || (state_q == S_STEP);
    assign halted  = (state_q == S_HALT);
    assign busy    = (state_q == S_DRD) || (state_q == S_DOUT);

    assign testreg         = idx_q;
    assign adv_cnt         = adv_q;
    assign dump.dump_valid = valid_q;
    assign dump.dump_data  = data_q;
    assign dump.dump_idx   = didx_q;
    assign dump.dump_done  = done_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
            idx_q   <= '0;
            lat_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            didx_q  <= '0;
            done_q  <= 1'b0;
            adv_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            lat_q   <= lat_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            didx_q  <= didx_d;
            done_q  <= done_d;
            if (pipe_en && wpcir) adv_q <= adv_q + ADV_W'(1);
        end
    end

    // Command decode: halt > step > run > dump; run is the only way out of a dump besides completion.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        lat_d   = lat_q;
        valid_d = valid_q;
        data_d  = data_q;
        didx_d  = didx_q;
        done_d  = 1'b0;
        case (state_q)
            S_RUN: begin
                if (cmd_halt) state_d = S_HALT;
            end
            S_HALT: begin
                if (!cmd_halt) begin
                    if (cmd_step) begin
                        if (step_n != CNT_W'(0)) begin
                            state_d = S_STEP;
                            cnt_d   = step_n;
                        end
                    end else if (cmd_run) begin
                        state_d = S_RUN;
                    end else if (cmd_dump) begin
                        state_d = S_DRD;
                        idx_d   = '0;
                        lat_d   = '0;
                    end
                end
            end
            S_STEP: begin
                if (cmd_halt) begin
                    state_d = S_HALT;
                    cnt_d   = '0;
                end else if (cmd_run) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else if (wpcir) begin
                    // Stall cycles leave the count alone so exactly step_n advances happen.
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state_d = S_HALT;
                end
            end
            S_DRD: begin
                if (cmd_run) begin
                    state_d = S_RUN;
                    valid_d = 1'b0;
                end else if (lat_q == LAT_W'(RD_LAT)) begin
                    data_d  = testdat;
                    didx_d  = idx_q;
                    valid_d = 1'b1;
                    state_d = S_DOUT;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            S_DOUT: begin
                if (cmd_run) begin
                    state_d = S_RUN;
                    valid_d = 1'b0;
                end else if (valid_q && dump.dump_ready) begin
                    valid_d = 1'b0;
                    if (idx_q == IDX_W'(31)) begin
                        done_d  = 1'b1;
                        state_d = S_HALT;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        lat_d   = '0;
                        state_d = S_DRD;
                    end
                end
            end
            default: state_d = RST_STATE;
        endcase
    end
endmodule

// File: doc/pipe_dbg_ctrl.md
# pipe_dbg_ctrl

Run/halt/single-step and register-dump controller for the 5-stage pipelined CPU. It gates pipeline advance through `pipe_en`, which the integrator ANDs into the PC and IF/ID write enables alongside the ID-stage `wpcir`. While the pipeline is halted, it walks the register-file debug read port (`testreg`/`testdat`) and streams all 32 registers out over a valid/ready handshake. It also counts pipeline-advance cycles for the debug host.

## Interface
Parameters:
- RESET_RUN, 1, state after reset: 1 = RUN, 0 = HALT
- RD_LAT, 1, cycles from `testreg` change to valid `testdat`; legal 1..3

Ports (one clock; reset is asynchronous and active-low):
- clock  in  1  system clock; all state updates on the rising edge
- resetn  in  1  asynchronous active-low reset
- cmd_run  in  1  one-cycle pulse: resume free-running execution
- cmd_halt  in  1  one-cycle pulse: stop pipeline advance
- cmd_step  in  1  one-cycle pulse: advance `step_n` cycles, then halt
- cmd_dump  in  1  one-cycle pulse: dump r0..r31
- step_n  in  8  step count, sampled with `cmd_step`
- wpcir  in  1  ID-stage advance flag; 0 = load-use stall this cycle
- testdat  in  32  register-file debug read data
- dump_ready  in  1  host accepts `dump_data`
- pipe_en  out  1  pipeline advance enable
- halted  out  1  state == HALT
- busy  out  1  dump in progress
- testreg  out  5  register-file debug read address
- dump_valid  out  1  `dump_data`/`dump_idx` are valid
- dump_data  out  32  captured register value
- dump_idx  out  5  register number of `dump_data`
- dump_done  out  1  one-cycle pulse after r31 is accepted
- adv_cnt  out  32  count of cycles with `pipe_en & wpcir`; wraps at 2^32

## Operation
- States: RUN, HALT, STEP, DRD (dump read), DOUT (dump output).
- `pipe_en` is combinational from state: 1 in RUN and STEP, 0 otherwise. `halted` and `busy` are also combinational from state (`busy` = DRD or DOUT). All other outputs are registered.
- Command priority when pulses coincide: halt > step > run > dump.
- RUN:
  - `cmd_halt` -> HALT.
  - `cmd_step` and `cmd_dump` are ignored.
- HALT:
  - `cmd_run` -> RUN.
  - `cmd_step` with `step_n != 0` -> STEP, with `cnt = step_n`; `step_n == 0` is a no-op.
  - `cmd_dump` -> DRD, with `idx = 0`.
- STEP:
  - Each cycle with `wpcir = 1`, `cnt` decrements. On the edge where `cnt == 1 && wpcir`, go to HALT.
  - Stall cycles (`wpcir = 0`) do not consume the count, so exactly `step_n` advancing cycles occur.
  - `cmd_halt` -> HALT immediately; the remaining count is discarded.
  - `cmd_run` -> RUN.
  - `cmd_step` is ignored.
- DRD:
  - `testreg = idx`; wait RD_LAT cycles.
  - Then capture `testdat` into `dump_data`, set `dump_idx = idx` and `dump_valid = 1`, and go to DOUT.
- DOUT:
  - Hold `dump_data`, `dump_idx` and `dump_valid` stable until `dump_ready` is seen.
  - On `dump_valid && dump_ready`: drop `dump_valid`. If `idx == 31`, pulse `dump_done` and go to HALT. Otherwise increment `idx` and go to DRD.
- During DRD/DOUT:
  - `cmd_halt`, `cmd_step` and `cmd_dump` are ignored.
  - `cmd_run` aborts the dump: `dump_valid` is cleared, `dump_done` is not pulsed, and the state goes to RUN.
- r0 is read through the port like any other register; no special-casing.
- `adv_cnt` increments on every edge where `pipe_en && wpcir`.

## Timing
- Reset values:
  - state = RUN if RESET_RUN else HALT, so `pipe_en = RESET_RUN` and `halted = !RESET_RUN`
  - `busy = 0`
  - `testreg = 0`, `dump_valid = 0`, `dump_data = 0`, `dump_idx = 0`, `dump_done = 0`
  - `adv_cnt = 0`, `cnt = 0`
- Reset mid-step or mid-dump returns to these values at once; any partial dump is lost.
- `cmd_halt` in cycle N: `pipe_en` is 0 from cycle N+1. The advance in cycle N still occurs if `wpcir` was 1.
- `cmd_step` in cycle N: `pipe_en` is 1 from cycle N+1. `pipe_en` falls in the cycle after the final advancing cycle.
- Dump word latency: `testreg` is driven in the first DRD cycle; `dump_valid` rises RD_LAT+1 cycles later.
  - With `dump_ready` held at 1, one word takes RD_LAT+2 cycles, and a full dump takes 32·(RD_LAT+2) cycles.
- `dump_done` is asserted in the cycle after the final handshake, coincident with `halted` rising.

## Test plan
- Reset with RESET_RUN=1, `wpcir=1` for 10 cycles -> `pipe_en=1` throughout, `adv_cnt=10`; `cmd_halt` -> `pipe_en=0` next cycle, and `adv_cnt` holds at 11.
- HALT, `cmd_step` with `step_n=3`, `wpcir` pattern 1,0,1,1 -> `pipe_en` high for exactly 4 cycles, 3 advances, then HALT; `step_n=0` -> stays HALT, `pipe_en=0`.
- STEP with `step_n=200`; `cmd_halt` after 5 advances -> HALT next cycle, `adv_cnt` +5 only; `cmd_halt` and `cmd_step` in the same cycle from HALT -> stays HALT.
- Dump with model regfile (reg k = 0x1000_0000 + k), `dump_ready=1`, RD_LAT=1 -> 32 words with `dump_idx` 0..31 and matching data, each 3 cycles apart, then a `dump_done` pulse, and `halted=1`.
- Dump with `dump_ready` low for 7 cycles on word 5 -> `dump_data=0x1000_0005` stable and `dump_valid` high throughout; no skipped or duplicated indices.
- `cmd_run` during word 12 of a dump -> `dump_valid=0` and `pipe_en=1` next cycle, no `dump_done`; async reset asserted mid-dump -> all outputs at reset values immediately.
